button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/pong_pkg.sv | 9 +
 rtl/debounce_channel.sv | 70 +++++++
 rtl/button_conditioner.sv | 49 ++++
 tb/tb_button_conditioner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong front-end: button channel count,
// debounce window and system clock rate.
package pong_pkg;

    localparam int unsigned NUM_BTN_DEF         = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned CLK_HZ              = 50000000;

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: two-flop synchronizer, stability counter,
// debounced state and registered press/release pulses.
module debounce_channel
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_n,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic press_next
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_q, s_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          btn_in;

    // Raw input is active-low; everything past the synchronizer is active-high.
    assign btn_in = ~sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], btn_raw_n};
        cnt_d   = cnt_q;
        s_d     = s_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (btn_in == s_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            s_d     = btn_in;
            cnt_d   = '0;
            press_d = btn_in;
            rel_d   = ~btn_in;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level         = s_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    // Exposed so the top can register any_press alongside press_q.
    assign press_next    = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN active-low pushbuttons and produces level, edge pulses
// and a combined serve/restart request.
module button_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned NUM_BTN         = NUM_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] PushButton,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    logic [NUM_BTN-1:0] press_next;
    logic               any_press_q, any_press_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk           (CLOCK_50),
            .reset         (reset),
            .btn_raw_n     (PushButton[i]),
            .level         (btn_level[i]),
            .press         (btn_press[i]),
            .release_pulse (btn_release[i]),
            .press_next    (press_next[i])
        );
    end

    always_comb begin
        any_press_d = |press_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce window.
module tb_button_conditioner;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [2:0] PushButton;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic       any_press;

    int checks = 0;
    int errors = 0;
    int press_cnt [3];
    int rel_cnt   [3];
    int any_cnt;
    int overlap_cnt;
    int any_bad_cnt;

    button_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (4)
    ) u_dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .PushButton  (PushButton),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance one rising edge, then observe 1 time unit later.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK_50);
            #1;
            for (int i = 0; i < 3; i++) begin
                press_cnt[i] += int'(btn_press[i]);
                rel_cnt[i]   += int'(btn_release[i]);
            end
            any_cnt += int'(any_press);
            if ((btn_press & btn_release) != 3'b000) overlap_cnt++;
            if (any_press != |btn_press) any_bad_cnt++;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        any_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        PushButton = 3'b111;
        tick(2);
        checks++;
        if ({btn_level, btn_press, btn_release, any_press} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000000",
                     {btn_level, btn_press, btn_release, any_press});
        end
        reset = 1'b0;
        tick(3);
        checks++;
        if ({btn_level, btn_press, btn_release, any_press} !== 10'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000000000",
                     {btn_level, btn_press, btn_release, any_press});
        end
    endtask

    task automatic test_clean_press();
        clear_counts();
        PushButton[0] = 1'b0;
        tick(5);
        checks++;
        if (btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL press_early: level0 got %b expected 0", btn_level[0]);
        end
        tick(1);
        checks++;
        if ({btn_level, btn_press, any_press} !== {3'b001, 3'b001, 1'b1}) begin
            errors++;
            $display("FAIL press_edge6: level/press/any got %b expected 0010011",
                     {btn_level, btn_press, any_press});
        end
        tick(1);
        checks++;
        if ({btn_level, btn_press, any_press} !== {3'b001, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL press_one_cycle: level/press/any got %b expected 0010000",
                     {btn_level, btn_press, any_press});
        end
        tick(10);
        checks++;
        if (press_cnt[0] != 1 || any_cnt != 1 || rel_cnt[0] != 0) begin
            errors++;
            $display("FAIL press_held: press %0d any %0d rel %0d expected 1 1 0",
                     press_cnt[0], any_cnt, rel_cnt[0]);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        PushButton[1] = 1'b0;
        tick(3);
        PushButton[1] = 1'b1;
        tick(10);
        checks++;
        if (btn_level[1] !== 1'b0 || press_cnt[1] != 0 || rel_cnt[1] != 0) begin
            errors++;
            $display("FAIL glitch: level1 %b press %0d rel %0d expected 0 0 0",
                     btn_level[1], press_cnt[1], rel_cnt[1]);
        end
    endtask

    task automatic test_bounce();
        clear_counts();
        PushButton[2] = 1'b0; tick(1);
        PushButton[2] = 1'b1; tick(1);
        PushButton[2] = 1'b0; tick(1);
        PushButton[2] = 1'b1; tick(1);
        PushButton[2] = 1'b0;
        tick(5);
        checks++;
        if (btn_level[2] !== 1'b0 || press_cnt[2] != 0) begin
            errors++;
            $display("FAIL bounce_early: level2 %b press %0d expected 0 0",
                     btn_level[2], press_cnt[2]);
        end
        tick(1);
        checks++;
        if (btn_press !== 3'b100 || btn_level[2] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_edge6: press %b level2 %b expected 100 1",
                     btn_press, btn_level[2]);
        end
        tick(10);
        checks++;
        if (press_cnt[2] != 1) begin
            errors++;
            $display("FAIL bounce_count: press2 %0d expected 1", press_cnt[2]);
        end
    endtask

    task automatic test_release();
        clear_counts();
        PushButton[0] = 1'b1;
        tick(5);
        checks++;
        if (btn_level[0] !== 1'b1 || btn_release !== 3'b000) begin
            errors++;
            $display("FAIL release_early: level0 %b release %b expected 1 000",
                     btn_level[0], btn_release);
        end
        tick(1);
        checks++;
        if ({btn_release, btn_press, any_press, btn_level[0]} !== {3'b001, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL release_edge6: rel/press/any/level0 got %b expected 00100000",
                     {btn_release, btn_press, any_press, btn_level[0]});
        end
        tick(10);
        checks++;
        if (rel_cnt[0] != 1 || press_cnt[0] != 0 || any_cnt != 0) begin
            errors++;
            $display("FAIL release_count: rel %0d press %0d any %0d expected 1 0 0",
                     rel_cnt[0], press_cnt[0], any_cnt);
        end
    endtask

    task automatic test_simultaneous();
        PushButton = 3'b111;
        tick(10);
        clear_counts();
        PushButton = 3'b000;
        tick(5);
        checks++;
        if (btn_press !== 3'b000 || any_press !== 1'b0) begin
            errors++;
            $display("FAIL simul_early: press %b any %b expected 000 0", btn_press, any_press);
        end
        tick(1);
        checks++;
        if (btn_press !== 3'b111 || any_press !== 1'b1 || btn_level !== 3'b111) begin
            errors++;
            $display("FAIL simul_edge6: press %b any %b level %b expected 111 1 111",
                     btn_press, any_press, btn_level);
        end
        tick(5);
        checks++;
        if (any_cnt != 1) begin
            errors++;
            $display("FAIL simul_any_once: any pulses %0d expected 1", any_cnt);
        end
    endtask

    task automatic test_reset_mid();
        PushButton = 3'b111;
        tick(10);
        clear_counts();
        PushButton[0] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({btn_level, btn_press, btn_release, any_press} !== 10'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 0000000000",
                     {btn_level, btn_press, btn_release, any_press});
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (btn_press !== 3'b000 || any_press !== 1'b0) begin
            errors++;
            $display("FAIL midreset_first_cycle: press %b any %b expected 000 0",
                     btn_press, any_press);
        end
        tick(4);
        checks++;
        if (btn_press !== 3'b000 || btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early: press %b level0 %b expected 000 0",
                     btn_press, btn_level[0]);
        end
        tick(1);
        checks++;
        if (btn_press !== 3'b001 || any_press !== 1'b1) begin
            errors++;
            $display("FAIL midreset_edge6: press %b any %b expected 001 1",
                     btn_press, any_press);
        end
        tick(5);
        checks++;
        if (press_cnt[0] != 1) begin
            errors++;
            $display("FAIL midreset_count: press0 %0d expected 1", press_cnt[0]);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL press_release_overlap: cycles %0d expected 0", overlap_cnt);
        end
        checks++;
        if (any_bad_cnt != 0) begin
            errors++;
            $display("FAIL any_press_or: mismatched cycles %0d expected 0", any_bad_cnt);
        end
    endtask

    initial begin
        reset       = 1'b1;
        PushButton  = 3'b111;
        overlap_cnt = 0;
        any_bad_cnt = 0;
        clear_counts();
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
